// File: rtl/alu_cmd_sequencer_if.sv
// ============================================================================
// Module   : alu_cmd_sequencer_if
// Purpose  : Command, ALU-drive and result handshake bundle for alu_cmd_sequencer
// Revision : 1.0
// ============================================================================
`default_nettype none

interface alu_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [2:0] alu_option;
  logic [3:0] alu_in1;
  logic [3:0] alu_in2;
  logic [3:0] alu_out;
  logic       alu_cout;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic       res_cout;
  logic       res_zero;
  logic       busy;
  logic [7:0] ops_done;

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, alu_cout, res_ready,
    output cmd_ready, alu_option, alu_in1, alu_in2,
           res_valid, res_data, res_cout, res_zero, busy, ops_done
  );

  // Producer / ALU / consumer side
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, alu_cout, res_ready,
    input  cmd_ready, alu_option, alu_in1, alu_in2,
           res_valid, res_data, res_cout, res_zero, busy, ops_done
  );
endinterface

`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
// ============================================================================
// Module   : alu_cmd_sequencer
// Purpose  : FIFO-buffered command front-end that drives a combinational ALU,
//            waits a settle time and registers the result behind valid/ready.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_cmd_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int DEPTH         = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_cmd_sequencer_if.slave   bus
);

  localparam int         c_AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int         c_CW          = 11;
  localparam logic [3:0] c_SETTLE_LOAD = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  state_t           r_state;
  logic [c_CW-1:0]  r_mem [DEPTH];
  logic [c_AW:0]    r_wptr;
  logic [c_AW:0]    r_rptr;
  logic [3:0]       r_cnt;
  logic [2:0]       r_alu_option;
  logic [3:0]       r_alu_in1;
  logic [3:0]       r_alu_in2;
  logic             r_res_valid;
  logic [3:0]       r_res_data;
  logic             r_res_cout;
  logic             r_res_zero;
  logic [7:0]       r_ops_done;

  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [c_CW-1:0]  w_head;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                   (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
  assign w_push  = bus.cmd_valid && !w_full;
  assign w_pop   = !w_empty &&
                   ((r_state == S_IDLE) ||
                    ((r_state == S_RESULT) && bus.res_ready));
  assign w_head  = r_mem[r_rptr[c_AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[c_AW-1:0]] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_alu_option <= 3'd0;
      r_alu_in1    <= 4'd0;
      r_alu_in2    <= 4'd0;
      r_res_valid  <= 1'b0;
      r_res_data   <= 4'd0;
      r_res_cout   <= 1'b0;
      r_res_zero   <= 1'b0;
      r_ops_done   <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {r_alu_option, r_alu_in1, r_alu_in2} <= w_head;
            r_cnt   <= c_SETTLE_LOAD;
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_res_data  <= bus.alu_out;
            r_res_cout  <= bus.alu_cout;
            r_res_zero  <= (bus.alu_out == 4'h0);
            r_res_valid <= 1'b1;
            r_state     <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_ops_done  <= r_ops_done + 8'd1;
            // Next command starts on the handshake edge to keep throughput
            if (w_pop) begin
              {r_alu_option, r_alu_in1, r_alu_in2} <= w_head;
              r_cnt   <= c_SETTLE_LOAD;
              r_state <= S_SETTLE;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = !w_full;
  assign bus.alu_option = r_alu_option;
  assign bus.alu_in1    = r_alu_in1;
  assign bus.alu_in2    = r_alu_in2;
  assign bus.res_valid  = r_res_valid;
  assign bus.res_data   = r_res_data;
  assign bus.res_cout   = r_res_cout;
  assign bus.res_zero   = r_res_zero;
  assign bus.busy       = (r_state != S_IDLE) || !w_empty;
  assign bus.ops_done   = r_ops_done;

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
// ============================================================================
// Module   : tb_alu_cmd_sequencer
// Purpose  : Directed self-checking bench for alu_cmd_sequencer (SETTLE 1 and 3)
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alu_cmd_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_cmd_sequencer_if b1 ();
  alu_cmd_sequencer_if b3 ();

  alu_cmd_sequencer #(.SETTLE_CYCLES(1), .DEPTH(2)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  alu_cmd_sequencer #(.SETTLE_CYCLES(3), .DEPTH(2)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b3)
  );

  always #5 clk = ~clk;

  // Small ALU stand-in: add, subtract, and, or
  function automatic logic [4:0] alu_model(input logic [2:0] op,
                                           input logic [3:0] a,
                                           input logic [3:0] b);
    case (op)
      3'b000:  return {1'b0, a} + {1'b0, b};
      3'b001:  return {1'b0, a} - {1'b0, b};
      3'b010:  return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  assign {b1.alu_cout, b1.alu_out} = alu_model(b1.alu_option, b1.alu_in1, b1.alu_in2);
  assign {b3.alu_cout, b3.alu_out} = alu_model(b3.alu_option, b3.alu_in1, b3.alu_in2);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    b1.cmd_valid = 0; b1.cmd_op = 0; b1.cmd_a = 0; b1.cmd_b = 0; b1.res_ready = 0;
    b3.cmd_valid = 0; b3.cmd_op = 0; b3.cmd_a = 0; b3.cmd_b = 0; b3.res_ready = 0;
    #2;
    checks++; if (b1.res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid: got %b expected 0", b1.res_valid); end
    checks++; if (b1.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b expected 1", b1.cmd_ready); end
    checks++; if (b1.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", b1.busy); end
    checks++; if (b1.ops_done !== 8'd0) begin errors++; $display("FAIL rst_ops_done: got %0d expected 0", b1.ops_done); end
    checks++; if ({b1.alu_option, b1.alu_in1, b1.alu_in2} !== 11'd0) begin errors++; $display("FAIL rst_alu_drive: got %h expected 0", {b1.alu_option, b1.alu_in1, b1.alu_in2}); end
    checks++; if ({b1.res_data, b1.res_cout, b1.res_zero} !== 6'd0) begin errors++; $display("FAIL rst_res_regs: got %h expected 0", {b1.res_data, b1.res_cout, b1.res_zero}); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_add();
    b1.res_ready = 1;
    b1.cmd_valid = 1; b1.cmd_op = 3'b000; b1.cmd_a = 4'h7; b1.cmd_b = 4'h5;
    tick();  // edge N: push
    b1.cmd_valid = 0;
    checks++; if (b1.res_valid !== 1'b0) begin errors++; $display("FAIL add_valid_N: got %b expected 0", b1.res_valid); end
    tick();  // edge N+1: pop and drive
    checks++; if ({b1.alu_in1, b1.alu_in2} !== 8'h75) begin errors++; $display("FAIL add_drive: got %h expected 75", {b1.alu_in1, b1.alu_in2}); end
    checks++; if (b1.res_valid !== 1'b0) begin errors++; $display("FAIL add_valid_N1: got %b expected 0", b1.res_valid); end
    checks++; if (b1.busy !== 1'b1) begin errors++; $display("FAIL add_busy: got %b expected 1", b1.busy); end
    tick();  // edge N+2: capture
    checks++; if (b1.res_valid !== 1'b1) begin errors++; $display("FAIL add_valid_N2: got %b expected 1", b1.res_valid); end
    checks++; if (b1.res_data !== 4'hC) begin errors++; $display("FAIL add_data: got %h expected c", b1.res_data); end
    checks++; if ({b1.res_cout, b1.res_zero} !== 2'b00) begin errors++; $display("FAIL add_flags: got %b expected 00", {b1.res_cout, b1.res_zero}); end
    tick();  // edge N+3: handshake
    checks++; if (b1.res_valid !== 1'b0) begin errors++; $display("FAIL add_valid_N3: got %b expected 0", b1.res_valid); end
    checks++; if (b1.ops_done !== 8'd1) begin errors++; $display("FAIL add_ops_done: got %0d expected 1", b1.ops_done); end
    checks++; if (b1.busy !== 1'b0) begin errors++; $display("FAIL add_idle: got %b expected 0", b1.busy); end
  endtask

  task automatic test_carry_zero();
    b1.res_ready = 1;
    b1.cmd_valid = 1; b1.cmd_op = 3'b000; b1.cmd_a = 4'hF; b1.cmd_b = 4'h1;
    tick();
    b1.cmd_valid = 0;
    tick();
    tick();
    checks++; if (b1.res_valid !== 1'b1) begin errors++; $display("FAIL cz_valid: got %b expected 1", b1.res_valid); end
    checks++; if ({b1.res_data, b1.res_cout, b1.res_zero} !== 6'b0000_11) begin errors++; $display("FAIL cz_result: got data %h cout %b zero %b expected 0 1 1", b1.res_data, b1.res_cout, b1.res_zero); end
    tick();
    checks++; if (b1.ops_done !== 8'd2) begin errors++; $display("FAIL cz_ops_done: got %0d expected 2", b1.ops_done); end
  endtask

  task automatic test_backpressure();
    logic [3:0] got_d [4];
    logic       got_c [4];
    logic [3:0] exp_d [4];
    logic       exp_c [4];
    logic       acc, hs;
    int         n;
    exp_d[0] = 4'h3; exp_c[0] = 1'b0;
    exp_d[1] = 4'h7; exp_c[1] = 1'b0;
    exp_d[2] = 4'h2; exp_c[2] = 1'b1;
    exp_d[3] = 4'h0; exp_c[3] = 1'b1;
    b1.res_ready = 0;
    b1.cmd_valid = 1; b1.cmd_op = 3'b000; b1.cmd_a = 4'h1; b1.cmd_b = 4'h2;
    tick();
    checks++; if (b1.cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b expected 1", b1.cmd_ready); end
    b1.cmd_a = 4'h3; b1.cmd_b = 4'h4;
    tick();
    checks++; if (b1.cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_ready2: got %b expected 1", b1.cmd_ready); end
    b1.cmd_a = 4'h9; b1.cmd_b = 4'h9;
    tick();
    checks++; if (b1.cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got %b expected 0", b1.cmd_ready); end
    b1.cmd_a = 4'h8; b1.cmd_b = 4'h8;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (b1.cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_stall[%0d]: cmd_ready got %b expected 0", i, b1.cmd_ready); end
      checks++; if ({b1.res_valid, b1.res_data, b1.res_cout} !== 6'b1_0011_0) begin errors++; $display("FAIL bp_hold[%0d]: got valid %b data %h cout %b expected 1 3 0", i, b1.res_valid, b1.res_data, b1.res_cout); end
    end
    checks++; if (b1.ops_done !== 8'd2) begin errors++; $display("FAIL bp_ops_hold: got %0d expected 2", b1.ops_done); end
    b1.res_ready = 1;
    n = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      acc = b1.cmd_valid && b1.cmd_ready;
      hs  = b1.res_valid && b1.res_ready;
      if (hs) begin
        if (n < 4) begin
          got_d[n] = b1.res_data;
          got_c[n] = b1.res_cout;
        end
        n++;
      end
      tick();
      if (acc) b1.cmd_valid = 0;
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL bp_count: got %0d results expected 4", n); end
    for (int i = 0; i < 4; i++) begin
      if (i < n) begin
        checks++; if ({got_d[i], got_c[i]} !== {exp_d[i], exp_c[i]}) begin errors++; $display("FAIL bp_order[%0d]: got %h/%b expected %h/%b", i, got_d[i], got_c[i], exp_d[i], exp_c[i]); end
      end
    end
    checks++; if (b1.ops_done !== 8'd6) begin errors++; $display("FAIL bp_ops_done: got %0d expected 6", b1.ops_done); end
    checks++; if (b1.busy !== 1'b0) begin errors++; $display("FAIL bp_drained: busy got %b expected 0", b1.busy); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] cmds   [3];
    logic [4:0]  exp_r  [3];
    logic [4:0]  got_r  [3];
    int          stamp  [3];
    logic [2:0]  first_op;
    logic        acc, hs;
    int          k, n;
    cmds[0] = {3'b001, 4'h9, 4'h3}; exp_r[0] = {1'b0, 4'h6};
    cmds[1] = {3'b000, 4'h8, 4'h9}; exp_r[1] = {1'b1, 4'h1};
    cmds[2] = {3'b010, 4'hC, 4'hA}; exp_r[2] = {1'b0, 4'h8};
    first_op = 3'b111;
    b1.res_ready = 1;
    k = 0; n = 0;
    b1.cmd_valid = 1; {b1.cmd_op, b1.cmd_a, b1.cmd_b} = cmds[0];
    for (int cyc = 0; cyc < 16; cyc++) begin
      acc = b1.cmd_valid && b1.cmd_ready;
      hs  = b1.res_valid && b1.res_ready;
      if (hs) begin
        if (n < 3) begin
          got_r[n] = {b1.res_cout, b1.res_data};
          stamp[n] = cyc;
          if (n == 0) first_op = b1.alu_option;
        end
        n++;
      end
      tick();
      if (acc) begin
        k++;
        if (k < 3) {b1.cmd_op, b1.cmd_a, b1.cmd_b} = cmds[k];
        else       b1.cmd_valid = 0;
      end
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", n); end
    if (n >= 3) begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (got_r[i] !== exp_r[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, got_r[i], exp_r[i]); end
      end
      checks++; if (stamp[0] !== 3) begin errors++; $display("FAIL b2b_latency: got cycle %0d expected 3", stamp[0]); end
      checks++; if ((stamp[1] - stamp[0]) !== 2 || (stamp[2] - stamp[1]) !== 2) begin errors++; $display("FAIL b2b_rate: got gaps %0d %0d expected 2 2", stamp[1] - stamp[0], stamp[2] - stamp[1]); end
      checks++; if (first_op !== 3'b001) begin errors++; $display("FAIL b2b_op_pass: got %b expected 001", first_op); end
    end
    checks++; if (b1.ops_done !== 8'd9) begin errors++; $display("FAIL b2b_ops_done: got %0d expected 9", b1.ops_done); end
  endtask

  task automatic test_settle();
    b3.res_ready = 1;
    b3.cmd_valid = 1; b3.cmd_op = 3'b000; b3.cmd_a = 4'h2; b3.cmd_b = 4'h3;
    tick();  // edge N
    b3.cmd_valid = 0;
    for (int j = 1; j <= 3; j++) begin
      tick();  // edges N+1..N+3
      checks++; if (b3.res_valid !== 1'b0) begin errors++; $display("FAIL settle_early[%0d]: got %b expected 0", j, b3.res_valid); end
      checks++; if ({b3.alu_in1, b3.alu_in2} !== 8'h23) begin errors++; $display("FAIL settle_drive[%0d]: got %h expected 23", j, {b3.alu_in1, b3.alu_in2}); end
    end
    tick();  // edge N+4
    checks++; if ({b3.res_valid, b3.res_data} !== 5'b1_0101) begin errors++; $display("FAIL settle_capture: got valid %b data %h expected 1 5", b3.res_valid, b3.res_data); end
    checks++; if ({b3.alu_in1, b3.alu_in2} !== 8'h23) begin errors++; $display("FAIL settle_drive_N4: got %h expected 23", {b3.alu_in1, b3.alu_in2}); end
    tick();
    checks++; if ({b3.res_valid, b3.ops_done} !== 9'h001) begin errors++; $display("FAIL settle_done: got valid %b ops %0d expected 0 1", b3.res_valid, b3.ops_done); end
  endtask

  task automatic test_reset_midop();
    b1.res_ready = 0;
    b1.cmd_valid = 1; b1.cmd_op = 3'b000; b1.cmd_a = 4'h3; b1.cmd_b = 4'h3;
    tick();
    b1.cmd_a = 4'h1; b1.cmd_b = 4'h1;
    tick();
    b1.cmd_valid = 0;
    for (int i = 0; i < 10 && !b1.res_valid; i++) tick();
    checks++; if ({b1.res_valid, b1.res_data} !== 5'b1_0110) begin errors++; $display("FAIL mid_pre: got valid %b data %h expected 1 6", b1.res_valid, b1.res_data); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if ({b1.res_valid, b1.res_data, b1.res_cout, b1.res_zero} !== 7'd0) begin errors++; $display("FAIL mid_res_clr: got %h expected 0", {b1.res_valid, b1.res_data, b1.res_cout, b1.res_zero}); end
    checks++; if ({b1.alu_option, b1.alu_in1, b1.alu_in2} !== 11'd0) begin errors++; $display("FAIL mid_alu_clr: got %h expected 0", {b1.alu_option, b1.alu_in1, b1.alu_in2}); end
    checks++; if ({b1.ops_done, b1.busy} !== 9'd0) begin errors++; $display("FAIL mid_cnt_clr: ops %0d busy %b expected 0 0", b1.ops_done, b1.busy); end
    checks++; if (b1.cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_cmd_ready: got %b expected 1", b1.cmd_ready); end
    checks++; if (b3.ops_done !== 8'd0) begin errors++; $display("FAIL mid_dut3_clr: got %0d expected 0", b3.ops_done); end
    tick();
    rst_n = 1'b1;
    b1.res_ready = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if ({b1.res_valid, b1.busy} !== 2'b00) begin errors++; $display("FAIL mid_no_ghost[%0d]: valid %b busy %b expected 0 0", i, b1.res_valid, b1.busy); end
    end
  endtask

  task automatic test_wrap();
    int   hs_cnt, acc_cnt;
    logic acc, hs;
    hs_cnt = 0; acc_cnt = 0;
    b1.res_ready = 1;
    b1.cmd_valid = 1; b1.cmd_op = 3'b000; b1.cmd_a = 4'h1; b1.cmd_b = 4'h2;
    for (int cyc = 0; cyc < 2000 && hs_cnt < 257; cyc++) begin
      acc = b1.cmd_valid && b1.cmd_ready;
      hs  = b1.res_valid && b1.res_ready;
      tick();
      if (acc) begin
        acc_cnt++;
        if (acc_cnt == 257) b1.cmd_valid = 0;
      end
      if (hs) begin
        hs_cnt++;
        if (hs_cnt == 256) begin
          checks++; if (b1.ops_done !== 8'd0) begin errors++; $display("FAIL wrap_256: got %0d expected 0", b1.ops_done); end
        end
      end
    end
    b1.cmd_valid = 0;
    checks++; if (hs_cnt !== 257) begin errors++; $display("FAIL wrap_timeout: got %0d handshakes expected 257", hs_cnt); end
    checks++; if (b1.ops_done !== 8'd1) begin errors++; $display("FAIL wrap_257: got %0d expected 1", b1.ops_done); end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_carry_zero();
    test_backpressure();
    test_back_to_back();
    test_settle();
    test_reset_midop();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command front-end for the 4-bit ALU (`ALUx4`). It accepts operation commands (opcode plus two 4-bit operands) through a valid/ready handshake and buffers them in a small FIFO. It drives each command onto the ALU's combinational inputs, waits a fixed settle time, then captures the 4-bit result and carry into a registered output with its own valid/ready handshake. It sits directly upstream of the ALU and turns the combinational ALU into a pipelined, flow-controlled datapath stage.

## Interface

Parameters:
- `SETTLE_CYCLES`, default 1: edges between driving ALU inputs and capturing the ALU result; legal range 1..15.
- `DEPTH`, default 2: command FIFO depth; power of two, minimum 2.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: a command is present.
- `cmd_ready` out 1: FIFO not full.
- `cmd_op` in 3: ALU option code; passed through unchanged.
- `cmd_a` in 4: operand 1.
- `cmd_b` in 4: operand 2.
- `alu_option` out 3: registered drive to ALU option.
- `alu_in1` out 4: registered drive to ALU in1.
- `alu_in2` out 4: registered drive to ALU in2.
- `alu_out` in 4: ALU result.
- `alu_cout` in 1: ALU carry out.
- `res_valid` out 1: result held and valid.
- `res_ready` in 1: consumer accepts the result.
- `res_data` out 4: captured result.
- `res_cout` out 1: captured carry.
- `res_zero` out 1: registered flag, 1 when captured result == 4'h0.
- `busy` out 1: FSM not in IDLE, or FIFO non-empty.
- `ops_done` out 8: count of completed result handshakes; wraps 255 -> 0.

## Operation

- Command push happens on an edge where `cmd_valid && cmd_ready`. `cmd_ready` depends only on the FIFO-full state; it never depends on `cmd_valid`.
- FIFO ordering:
  - Strict FIFO order.
  - Push and pop on the same edge are both allowed when the FIFO is non-empty; occupancy is then unchanged.
  - No bypass: a command pushed into an empty FIFO is popped no earlier than the next edge.
- FSM states: IDLE, SETTLE, RESULT.
  - **IDLE.** If the FIFO is non-empty, pop the head, load `alu_option`/`alu_in1`/`alu_in2`, load the settle counter with `SETTLE_CYCLES`, and go to SETTLE. Otherwise stay in IDLE.
  - **SETTLE.** The counter decrements each edge. On the edge where the counter == 1:
    - capture `alu_out` into `res_data`, `alu_cout` into `res_cout`, and (`alu_out` == 0) into `res_zero`;
    - set `res_valid`;
    - go to RESULT.
  - **RESULT.** Hold the result registers. On an edge with `res_ready`:
    - clear `res_valid` and increment `ops_done`;
    - if the FIFO is non-empty, pop and drive the ALU on that same edge and go to SETTLE; otherwise go to IDLE.
- The ALU input registers hold their last values in IDLE and RESULT; they change only on a pop.
- The block does not interpret `cmd_op`; all opcodes are treated identically.
- Reset (asynchronous, at any time including mid-SETTLE or in RESULT):
  - FIFO emptied, state IDLE, counters 0;
  - all outputs 0, except `cmd_ready` = 1;
  - in-flight and queued commands are discarded, never emitted.

## Timing

- A command accepted at edge N (FIFO previously empty, FSM in IDLE):
  - pop and ALU drive at edge N+1;
  - capture at edge N+1+SETTLE_CYCLES;
  - `res_valid` high from that edge.
- Back-to-back throughput with `res_ready` held high: one result per SETTLE_CYCLES+1 clocks.
- `res_valid`, `res_data`, `res_cout` and `res_zero` are stable while `res_valid && !res_ready`.
- `alu_*` outputs are stable for the whole SETTLE period; the capture samples the ALU output at least one full clock after the drive.
- `cmd_ready` falls the edge after the FIFO becomes full and rises the edge after a pop from full.

## Test plan

1. **Reset.** Drive `rst_n` low between edges mid-operation -> all outputs 0 immediately, `cmd_ready` = 1; after release, no `res_valid` until a new command is accepted.
2. **Single add.** SETTLE_CYCLES = 1, `res_ready` = 1, `op` = 3'b000, `a` = 4'h7, `b` = 4'h5, ALU model returns 4'hC / cout 0. Required:
   - `alu_in1` = 7 and `alu_in2` = 5 after edge N+1;
   - `res_valid` high for exactly one cycle after edge N+2;
   - `res_data` = 4'hC, `res_zero` = 0;
   - `ops_done` = 1.
3. **Carry/zero.** `a` = 4'hF, `b` = 4'h1 -> `res_data` = 4'h0, `res_cout` = 1, `res_zero` = 1.
4. **Backpressure.** DEPTH = 2, `res_ready` = 0, push 4 commands. Required:
   - the first result is held stable;
   - `cmd_ready` drops after the 3rd accept and the 4th command stalls;
   - after `res_ready` = 1, all 4 results emerge in order and `ops_done` = 4.
5. **Settle length.** SETTLE_CYCLES = 3 -> `res_valid` after edge N+4; `alu_in*` unchanged from N+1 to N+4.
6. **Wrap.** 257 completed handshakes -> `ops_done` = 1.
